// File: rtl/jpc_fetch_pkg.sv
// Shared widths, PC step and fetch FSM state encoding for the jpc fetch stage.
package jpc_fetch_pkg;

    localparam int JPC_ADDRESS_WIDTH = 32;
    localparam int JPC_INSTR_WIDTH   = 32;
    localparam int JPC_PC_STEP       = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/jpc_fetch_buf.sv
// Two-entry (output + skid) valid/ready buffer with a synchronous flush.
// The output register always holds the older entry, so order is preserved.
module jpc_fetch_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  skid_valid,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  out_free;

    assign out_free = !out_valid || out_ready;

    // The producer never offers data while the skid is full and the output stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_data <= in_data;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/jpc_fetch.sv
// Instruction fetch stage: one outstanding imem request, PC feedback to jpc_pc,
// (pc, instr) delivery to decode, and redirect flush with stale-response drop.
module jpc_fetch #(
    parameter int JPC_ADDRESS_WIDTH = jpc_fetch_pkg::JPC_ADDRESS_WIDTH,
    parameter int JPC_INSTR_WIDTH   = jpc_fetch_pkg::JPC_INSTR_WIDTH,
    parameter int JPC_PC_STEP       = jpc_fetch_pkg::JPC_PC_STEP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [JPC_ADDRESS_WIDTH-1:0] pc_I,
    output logic [JPC_ADDRESS_WIDTH-1:0] next_pc_O,
    output logic                         pc_enable_O,
    input  logic                         redirect_I,
    input  logic [JPC_ADDRESS_WIDTH-1:0] redirect_pc_I,
    output logic                         imem_req_O,
    output logic [JPC_ADDRESS_WIDTH-1:0] imem_addr_O,
    input  logic                         imem_gnt_I,
    input  logic                         imem_rvalid_I,
    input  logic [JPC_INSTR_WIDTH-1:0]   imem_rdata_I,
    output logic                         instr_valid_O,
    output logic [JPC_INSTR_WIDTH-1:0]   instr_O,
    output logic [JPC_ADDRESS_WIDTH-1:0] instr_pc_O,
    input  logic                         instr_ready_I
);

    import jpc_fetch_pkg::*;

    localparam int AW = JPC_ADDRESS_WIDTH;
    localparam int IW = JPC_INSTR_WIDTH;

    fetch_state_t    state, state_next;
    logic [AW-1:0]   req_pc_q;
    logic            req;
    logic            buf_in_valid;
    logic            skid_valid;
    logic [IW+AW-1:0] buf_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            req_pc_q <= '0;
        end else begin
            state <= state_next;
            if (req && imem_gnt_I) begin
                req_pc_q <= pc_I;
            end
        end
    end

    always_comb begin
        state_next   = state;
        req          = 1'b0;
        buf_in_valid = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                req = !redirect_I && !skid_valid;
                if (req && imem_gnt_I) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response landing with a redirect belongs to the old path.
                if (imem_rvalid_I) begin
                    buf_in_valid = !redirect_I;
                    state_next   = S_REQ;
                end else if (redirect_I) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_I) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_req_O  = req;
    assign imem_addr_O = (state == S_REQ) ? pc_I : '0;

    // PC feedback is forced to zero while reset is held so every output reads 0.
    assign pc_enable_O = rst && (redirect_I || (req && imem_gnt_I));
    assign next_pc_O   = !rst       ? '0 :
                         redirect_I ? (redirect_pc_I & ~AW'(3)) :
                                      pc_I + AW'(JPC_PC_STEP);

    jpc_fetch_buf #(
        .DATA_WIDTH(IW + AW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_I),
        .in_valid  (buf_in_valid),
        .in_data   ({imem_rdata_I, req_pc_q}),
        .skid_valid(skid_valid),
        .out_valid (instr_valid_O),
        .out_data  (buf_out),
        .out_ready (instr_ready_I)
    );

    assign instr_O    = buf_out[IW+AW-1:AW];
    assign instr_pc_O = buf_out[AW-1:0];

endmodule

// File: tb/tb_jpc_fetch.sv
// Directed bench for jpc_fetch with a jpc_pc register model and a latency-programmable memory.
module tb_jpc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    logic        gnt_en;
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    logic [63:0] delivered[$];
    int          hold_viol = 0;
    logic        was_stalled;
    logic [63:0] held;

    int n0, n1, n2, n3;

    always #5 clk = ~clk;

    jpc_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_I         (pc),
        .next_pc_O    (next_pc),
        .pc_enable_O  (pc_enable),
        .redirect_I   (redirect),
        .redirect_pc_I(redirect_pc),
        .imem_req_O   (imem_req),
        .imem_addr_O  (imem_addr),
        .imem_gnt_I   (imem_gnt),
        .imem_rvalid_I(imem_rvalid),
        .imem_rdata_I (imem_rdata),
        .instr_valid_O(instr_valid),
        .instr_O      (instr),
        .instr_pc_O   (instr_pc),
        .instr_ready_I(instr_ready)
    );

    // jpc_pc model
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'h0;
        else if (pc_enable) pc <= next_pc;
    end

    // Memory: grants when enabled, answers lat cycles after the grant cycle.
    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = pend && (cnt == 1);
    assign imem_rdata  = paddr ^ 32'hA5A5_0000;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= 32'h0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            else if (pend) cnt <= cnt - 1;
            if (imem_req && imem_gnt) begin
                pend  <= 1'b1;
                cnt   <= lat;
                paddr <= imem_addr;
            end
        end
    end

    // Decode-side monitor: log transfers, flag output changes under stall.
    always @(posedge clk) begin
        if (rst) begin
            if (instr_valid && instr_ready) delivered.push_back({instr_pc, instr});
            if (was_stalled && instr_valid && ({instr_pc, instr} != held))
                hold_viol <= hold_viol + 1;
            was_stalled <= instr_valid && !instr_ready;
            held        <= {instr_pc, instr};
        end else begin
            was_stalled <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout observed=0 expected=1", tag);
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (imem_req && imem_gnt) return;
        end
        timeout(tag);
    endtask

    task automatic wait_req_addr(input string tag, input logic [31:0] a);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (imem_req && imem_addr == a) return;
        end
        timeout(tag);
    endtask

    task automatic wait_count(input string tag, input int n);
        for (int i = 0; i < 100; i++) begin
            if (delivered.size() >= n) return;
            tick();
        end
        timeout(tag);
    endtask

    function automatic logic [63:0] entry(input int idx);
        if (idx < delivered.size()) return delivered[idx];
        return 64'h0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   64'(instr_valid), 64'h0);
        check({tag, "_instr"},   64'(instr),       64'h0);
        check({tag, "_ipc"},     64'(instr_pc),    64'h0);
        check({tag, "_req"},     64'(imem_req),    64'h0);
        check({tag, "_addr"},    64'(imem_addr),   64'h0);
        check({tag, "_pcen"},    64'(pc_enable),   64'h0);
        check({tag, "_nextpc"},  64'(next_pc),     64'h0);
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        gnt_en = 1'b1; lat = 1; instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");

        // 1: sequential fetch 0x0, 0x4, 0x8
        rst = 1'b1;
        tick();
        check("t1_req",    64'(imem_req),  64'h1);
        check("t1_addr",   64'(imem_addr), 64'h0);
        check("t1_pcen",   64'(pc_enable), 64'h1);
        check("t1_nextpc", 64'(next_pc),   64'h4);
        tick();
        check("t1_wait_req",  64'(imem_req),    64'h0);
        check("t1_wait_pcen", 64'(pc_enable),   64'h0);
        check("t1_wait_val",  64'(instr_valid), 64'h0);
        tick();
        check("t1_val",   64'(instr_valid), 64'h1);
        check("t1_ipc",   64'(instr_pc),    64'h0);
        check("t1_instr", 64'(instr),       64'hA5A5_0000);
        wait_count("t1_count", 3);
        check("t1_q0", entry(0), 64'h0000_0000_A5A5_0000);
        check("t1_q1", entry(1), 64'h0000_0004_A5A5_0004);
        check("t1_q2", entry(2), 64'h0000_0008_A5A5_0008);

        // 2: grant withheld at 0x10
        wait_req_addr("t2_reach", 32'h10);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            check("t2_req",  64'(imem_req),  64'h1);
            check("t2_addr", 64'(imem_addr), 64'h10);
            check("t2_pcen", 64'(pc_enable), 64'h0);
            check("t2_pc",   64'(pc),        64'h10);
        end
        tick();
        gnt_en = 1'b1;
        #1;
        check("t2_gnt_pcen",   64'(pc_enable), 64'h1);
        check("t2_gnt_nextpc", 64'(next_pc),   64'h14);

        // 3: decode stalls 6 cycles, output and skid fill
        n0 = delivered.size();
        check("t3_n0", 64'(n0), 64'd4);
        instr_ready = 1'b0;
        tick();
        tick();
        check("t3_req14",  64'(imem_req),  64'h1);
        check("t3_addr14", 64'(imem_addr), 64'h14);
        tick();
        tick();
        check("t3_full_req", 64'(imem_req),    64'h0);
        check("t3_full_val", 64'(instr_valid), 64'h1);
        check("t3_full_ipc", 64'(instr_pc),    64'h10);
        tick();
        check("t3_full_req2", 64'(imem_req), 64'h0);
        tick();
        instr_ready = 1'b1;
        wait_count("t3_count", n0 + 3);
        check("t3_q0", entry(n0),     64'h0000_0010_A5A5_0010);
        check("t3_q1", entry(n0 + 1), 64'h0000_0014_A5A5_0014);
        check("t3_q2", entry(n0 + 2), 64'h0000_0018_A5A5_0018);

        // 4: redirect to 0x103 in S_WAIT, stale response 2 cycles later
        lat = 3;
        wait_grant("t4_grant");
        tick();
        n1 = delivered.size();
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        check("t4_nextpc", 64'(next_pc),   64'h100);
        check("t4_pcen",   64'(pc_enable), 64'h1);
        check("t4_req",    64'(imem_req),  64'h0);
        tick();
        redirect = 1'b0;
        #1;
        check("t4_flush_val", 64'(instr_valid), 64'h0);
        check("t4_drain_req", 64'(imem_req),    64'h0);
        tick();
        check("t4_stale_req", 64'(imem_req), 64'h0);
        tick();
        check("t4_req100",  64'(imem_req),  64'h1);
        check("t4_addr100", 64'(imem_addr), 64'h100);
        wait_count("t4_count", n1 + 1);
        check("t4_first", entry(n1), 64'h0000_0100_A5A5_0100);

        // 5: redirect coinciding with rvalid while 0x20 sits unconsumed
        lat = 1;
        instr_ready = 1'b0;
        wait_grant("t5_grant");
        tick();
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        check("t5_nextpc20", 64'(next_pc), 64'h20);
        tick();
        redirect = 1'b0;
        #1;
        check("t5_val0",  64'(instr_valid), 64'h0);
        check("t5_req20", 64'(imem_req),    64'h1);
        check("t5_addr20", 64'(imem_addr),  64'h20);
        tick();
        tick();
        check("t5_hold_val", 64'(instr_valid), 64'h1);
        check("t5_hold_ipc", 64'(instr_pc),    64'h20);
        check("t5_addr24",   64'(imem_addr),   64'h24);
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        check("t5_rvalid_cycle", 64'(imem_rvalid), 64'h1);
        tick();
        redirect = 1'b0;
        #1;
        check("t5_flush_val", 64'(instr_valid), 64'h0);
        check("t5_addr40",    64'(imem_addr),   64'h40);
        n2 = delivered.size();
        check("t5_none_delivered", 64'(n2), 64'(n1 + 1));
        instr_ready = 1'b1;
        wait_count("t5_count", n2 + 1);
        check("t5_first", entry(n2), 64'h0000_0040_A5A5_0040);

        // 6: reset mid-S_WAIT
        lat = 3;
        wait_grant("t6_grant");
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        tick();
        tick();
        rst = 1'b1;
        n3 = delivered.size();
        tick();
        check("t6_req",  64'(imem_req),  64'h1);
        check("t6_addr", 64'(imem_addr), 64'h0);
        wait_count("t6_count", n3 + 1);
        check("t6_first", entry(n3), 64'h0000_0000_A5A5_0000);

        check("hold_stable", 64'(hold_viol), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpc_fetch.md
Name: jpc_fetch

Overview:
Instruction fetch stage that sits directly downstream of jpc_pc and closes the loop back into it.
- Consumes the current PC and issues one instruction-memory request at a time.
- Drives next_pc and pc_enable back into jpc_pc.
- Delivers fetched instructions, each tagged with its PC, to decode over a valid/ready handshake.
- Handles redirects (branch/jump/exception) by flushing buffered instructions and discarding in-flight responses.

Parameters:
- JPC_ADDRESS_WIDTH, 32, width of the PC and memory address.
- JPC_INSTR_WIDTH, 32, instruction word width.
- JPC_PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_I  input  JPC_ADDRESS_WIDTH  current PC from jpc_pc.
- next_pc_O  output  JPC_ADDRESS_WIDTH  next PC to jpc_pc.
- pc_enable_O  output  1  PC update strobe to jpc_pc.
- redirect_I  input  1  one-cycle redirect pulse from execute.
- redirect_pc_I  input  JPC_ADDRESS_WIDTH  redirect target.
- imem_req_O  output  1  memory request valid.
- imem_addr_O  output  JPC_ADDRESS_WIDTH  request address.
- imem_gnt_I  input  1  request accepted this cycle.
- imem_rvalid_I  input  1  response data valid.
- imem_rdata_I  input  JPC_INSTR_WIDTH  response instruction.
- instr_valid_O  output  1  instruction available to decode.
- instr_O  output  JPC_INSTR_WIDTH  instruction.
- instr_pc_O  output  JPC_ADDRESS_WIDTH  PC of instr_O.
- instr_ready_I  input  1  decode accepts.

Behaviour:
Reset (rst low, asynchronous):
- state=S_IDLE; output register, skid register and req_pc_q cleared.
- All outputs are 0.

State machine:
- S_IDLE goes to S_REQ on the first clock after reset deasserts.
- S_REQ:
  - imem_req_O = !redirect_I && !skid_valid.
  - imem_addr_O = pc_I.
  - On req && gnt: req_pc_q <= pc_I and go to S_WAIT.
  - The request is held, with a stable address, until granted. The only exception is a redirect, which may withdraw it.
- S_WAIT (exactly one outstanding request):
  - On rvalid, the instruction and req_pc_q are written into the output register if it is empty or consumed this cycle. Otherwise they are written into the skid register. Then go to S_REQ.
- S_DRAIN:
  - Waits for the stale response, which is discarded; then go to S_REQ.

PC interface (combinational):
- pc_enable_O = redirect_I || (imem_req_O && imem_gnt_I).
- next_pc_O = redirect_I ? {redirect_pc_I[W-1:2],2'b00} : pc_I + JPC_PC_STEP. Wraps modulo 2^W.

Output handshake:
- instr_O and instr_pc_O are held stable while instr_valid_O && !instr_ready_I.
- A transfer occurs when both are high.
- When the output is consumed, the skid entry, if present, moves to the output on the next cycle.
- Order is preserved: PCs are delivered strictly in fetch order.
- Latency: gnt to rvalid is memory-defined. rvalid to instr_valid_O is 1 cycle.

Redirect (any state):
- Output and skid valid bits clear the next cycle.
- In S_WAIT without a same-cycle rvalid, go to S_DRAIN.
- In S_WAIT with a same-cycle rvalid, that response is dropped and the state goes to S_REQ.
- In S_DRAIN, stay in S_DRAIN.
- In S_REQ, no request is issued that cycle.
- The first post-redirect request uses the redirect target, now in jpc_pc.

Other boundary rules:
- Skid full: no new request until the skid drains.
- A reset mid-transaction abandons any in-flight response. The memory is reset by the same rst.

Decomposition:
- Shared package/include (jpc_config.v): JPC_ADDRESS_WIDTH, JPC_INSTR_WIDTH, JPC_PC_STEP, and state encodings S_IDLE, S_REQ, S_WAIT, S_DRAIN.
- One natural sub-module, jpc_fetch_buf: a 2-entry (output + skid) valid/ready buffer with flush input.

Test Plan:
1. Reset then release, memory grants immediately with 1-cycle rvalid, pc_I from jpc_pc starting at 0 -> requests to 0x0, 0x4, 0x8; decode receives (pc,instr) 0x0, 0x4, 0x8 in order; pc_enable_O pulses once per grant.
2. imem_gnt_I low for 3 cycles at address 0x10 -> imem_req_O stays high with imem_addr_O=0x10, pc_enable_O=0, no PC advance.
3. instr_ready_I low for 6 cycles -> output and skid fill, imem_req_O drops; no instruction is lost or duplicated when ready returns.
4. Redirect to 0x103 while in S_WAIT, rvalid 2 cycles later -> next_pc_O=0x100, stale response discarded, next delivered instr_pc_O=0x100.
5. Redirect in the same cycle as rvalid, with the output holding 0x20 un-consumed -> instr_valid_O=0 next cycle and neither 0x20 nor the in-flight response is delivered.
6. Assert rst low mid-S_WAIT, release -> all outputs 0, fetch restarts cleanly from jpc_pc reset value 0.
